// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared 8:1 single-bit mux; sel drives the mux S input.
// Latency: one cycle from req to registered gnt/sel/valid.
// Backpressure: none; an owner keeps the mux while it requests, for at most MAX_HOLD cycles.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       valid
);

    localparam int CW = $clog2(MAX_HOLD) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [2:0]    ptr;
    logic [2:0]    owner;
    logic [CW-1:0] hold_cnt;

    logic          release_now;
    logic [2:0]    arb_ptr;
    logic [2:0]    cand;
    logic [2:0]    win_idx;
    logic          win_vld;

    assign sel = owner;

    // On a release the scan starts just past the old owner in the same cycle,
    // so a lone requester that timed out is found again after the wrap.
    always_comb begin
        release_now = (state == GRANT) && (!req[owner] || (hold_cnt == HOLD_LAST));
        arb_ptr     = release_now ? owner + 3'd1 : ptr;
        win_vld     = 1'b0;
        win_idx     = arb_ptr;
        cand        = arb_ptr;
        for (int i = 7; i >= 0; i--) begin
            cand = arb_ptr + 3'(i);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 8'h00;
            owner    <= 3'd0;
            valid    <= 1'b0;
            ptr      <= 3'd0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt      <= 8'(1) << win_idx;
                        owner    <= win_idx;
                        valid    <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                default: begin
                    if (!release_now) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        ptr <= arb_ptr;
                        if (win_vld) begin
                            gnt      <= 8'(1) << win_idx;
                            owner    <= win_idx;
                            valid    <= 1'b1;
                            hold_cnt <= '0;
                            state    <= GRANT;
                        end else begin
                            // sel keeps the last owner while idle
                            gnt      <= 8'h00;
                            valid    <= 1'b0;
                            hold_cnt <= '0;
                            state    <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed checks for mux_rr_arbiter with MAX_HOLD=4: a vector table plus rotation and hold sequences.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;

    int total;
    int bad;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       vld;
    } vec_t;

    vec_t vt[13];

    mux_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] eg, input logic [2:0] es, input logic ev);
        check({tag, ".gnt"}, gnt, eg);
        check({tag, ".sel"}, {5'd0, sel}, {5'd0, es});
        check({tag, ".valid"}, {7'd0, valid}, {7'd0, ev});
    endtask

    initial begin
        logic [2:0] es;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 8'h00;

        vt[0]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0};
        vt[1]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0};
        vt[2]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
        vt[3]  = '{1'b0, 8'h24, 8'h04, 3'd2, 1'b1};
        vt[4]  = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1};
        vt[5]  = '{1'b0, 8'h00, 8'h00, 3'd5, 1'b0};
        vt[6]  = '{1'b0, 8'h81, 8'h80, 3'd7, 1'b1};
        vt[7]  = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1};
        vt[8]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
        vt[9]  = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1};
        vt[10] = '{1'b1, 8'h20, 8'h00, 3'd0, 1'b0};
        vt[11] = '{1'b0, 8'hA0, 8'h20, 3'd5, 1'b1};
        vt[12] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};

        #2;
        for (int i = 0; i < 13; i++) begin
            step(vt[i].rst, vt[i].req);
            check_out($sformatf("vec%0d", i), vt[i].gnt, vt[i].sel, vt[i].vld);
        end

        // All requesting: each index owns the mux for exactly 4 cycles, in order.
        for (int c = 0; c < 33; c++) begin
            step(1'b0, 8'hFF);
            es = 3'((c / 4) % 8);
            check_out($sformatf("rot%0d", c), 8'(1) << es, es, 1'b1);
        end

        step(1'b1, 8'h00);
        check_out("rst_before_solo", 8'h00, 3'd0, 1'b0);

        // Lone requester keeps the grant across hold timeouts with no gap.
        for (int c = 0; c < 13; c++) begin
            step(1'b0, 8'h08);
            check_out($sformatf("solo%0d", c), 8'h08, 3'd3, 1'b1);
        end

        step(1'b0, 8'h00);
        check_out("solo_release", 8'h00, 3'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
